// File: rtl/lfsr_parity_checker.sv
`default_nettype none
// ============================================================================
// Module : lfsr_parity_checker
// Brief  : PRBS-7 (x^7+x^6+1) receive checker with parity and sequence
//          checking, self-synchronisation and saturating error statistics.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr_parity_checker #(
  parameter int SYNC_LEN = 4,
  parameter int LOSS_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [3:0]       C_SYNC_LEN = 4'(SYNC_LEN);
  localparam logic [3:0]       C_LOSS_LEN = 4'(LOSS_LEN);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [6:0]       r_expected, w_expected_nxt;
  logic [3:0]       r_run, w_run_nxt;
  logic [3:0]       r_bad_run, w_bad_run_nxt;
  logic             r_err_pulse, w_err_pulse_nxt;
  logic             r_parity_err, w_parity_err_nxt;
  logic [CNT_W-1:0] r_err_count, w_err_count_nxt;
  logic [CNT_W-1:0] r_word_count, w_word_count_nxt;
  logic             w_good_par, w_match, w_word_inc, w_err_inc;
  logic [3:0]       w_run_inc, w_bad_run_inc;

  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  assign w_good_par    = (data_in[7] == ~^data_in[6:0]);
  assign w_match       = (data_in[6:0] == r_expected);
  assign w_run_inc     = r_run + 4'd1;
  assign w_bad_run_inc = r_bad_run + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SEARCH;
      r_expected   <= 7'd0;
      r_run        <= 4'd0;
      r_bad_run    <= 4'd0;
      r_err_pulse  <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_expected   <= w_expected_nxt;
      r_run        <= w_run_nxt;
      r_bad_run    <= w_bad_run_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_err_count  <= w_err_count_nxt;
      r_word_count <= w_word_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_expected_nxt   = r_expected;
    w_run_nxt        = r_run;
    w_bad_run_nxt    = r_bad_run;
    w_err_pulse_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_word_inc       = 1'b0;
    w_err_inc        = 1'b0;
    if (data_valid) begin
      w_parity_err_nxt = ~w_good_par;
      if (r_state == ST_SEARCH) begin
        // The all-zero word is the LFSR lockup state and can never seed the search.
        if (w_good_par && (data_in[6:0] != 7'd0)) begin
          w_expected_nxt = lfsr_next(data_in[6:0]);
          w_run_nxt      = w_match ? w_run_inc : 4'd1;
          if (w_run_nxt == C_SYNC_LEN) begin
            w_state_nxt = ST_LOCKED;
            w_run_nxt   = 4'd0;
          end
        end else begin
          w_run_nxt = 4'd0;
        end
      end else begin
        // Flywheel: received data never re-seeds the expected value once locked.
        w_expected_nxt = lfsr_next(r_expected);
        w_word_inc     = 1'b1;
        if (w_good_par && w_match) begin
          w_bad_run_nxt = 4'd0;
        end else begin
          w_err_pulse_nxt = 1'b1;
          w_err_inc       = 1'b1;
          w_bad_run_nxt   = w_bad_run_inc;
          if (w_bad_run_inc == C_LOSS_LEN) begin
            w_state_nxt   = ST_SEARCH;
            w_run_nxt     = 4'd0;
            w_bad_run_nxt = 4'd0;
          end
        end
      end
    end
  end

  always_comb begin
    w_err_count_nxt  = r_err_count;
    w_word_count_nxt = r_word_count;
    if (clr_cnt) begin
      w_err_count_nxt  = '0;
      w_word_count_nxt = '0;
    end else begin
      if (w_word_inc && (r_word_count != C_CNT_MAX)) begin
        w_word_count_nxt = r_word_count + C_CNT_ONE;
      end
      if (w_err_inc && (r_err_count != C_CNT_MAX)) begin
        w_err_count_nxt = r_err_count + C_CNT_ONE;
      end
    end
  end

  assign locked     = (r_state == ST_LOCKED);
  assign err_pulse  = r_err_pulse;
  assign parity_err = r_parity_err;
  assign err_count  = r_err_count;
  assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_parity_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_lfsr_parity_checker
// Brief  : Self-checking bench for lfsr_parity_checker against a behavioural
//          model of the PRBS-7 sync/lock/statistics rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lfsr_parity_checker;

  localparam int SYNC_LEN = 4;
  localparam int LOSS_LEN = 3;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int VW       = 3 + 2 * CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             clr_cnt;
  logic             locked, err_pulse, parity_err;
  logic [CNT_W-1:0] err_count, word_count;
  logic [VW-1:0]    dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_locked, m_ep, m_pe;
  int m_exp, m_run, m_bad, m_err, m_word;
  int tx;

  lfsr_parity_checker #(
    .SYNC_LEN(SYNC_LEN), .LOSS_LEN(LOSS_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
    .parity_err(parity_err), .err_count(err_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {locked, err_pulse, parity_err, err_count, word_count};

  function automatic int nxt7(input int s);
    return ((s << 1) & 127) | (((s >> 6) ^ (s >> 5)) & 1);
  endfunction

  // Parity bit is 1 exactly when the 7-bit state holds an even number of ones.
  function automatic logic [7:0] mk_word(input int s);
    logic [6:0] s7;
    s7 = 7'(s);
    return {(($countones(s7) % 2) == 0) ? 1'b1 : 1'b0, s7};
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_ep = 0; m_pe = 0;
    m_exp = 0; m_run = 0; m_bad = 0; m_err = 0; m_word = 0;
  endfunction

  function automatic void model_step(input logic [7:0] d, input logic v, input logic c);
    bit gp, mt;
    int s;
    m_ep = 0; m_pe = 0;
    if (v) begin
      s  = int'(d[6:0]);
      gp = (d[7] == (($countones(d[6:0]) % 2) == 0));
      mt = (s == m_exp);
      m_pe = !gp;
      if (!m_locked) begin
        if (gp && s != 0) begin
          m_run = mt ? m_run + 1 : 1;
          m_exp = nxt7(s);
          if (m_run == SYNC_LEN) begin m_locked = 1; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else begin
        m_exp = nxt7(m_exp);
        if (m_word < CNT_MAX) m_word++;
        if (gp && mt) begin
          m_bad = 0;
        end else begin
          m_ep = 1;
          if (m_err < CNT_MAX) m_err++;
          m_bad++;
          if (m_bad == LOSS_LEN) begin m_locked = 0; m_run = 0; m_bad = 0; end
        end
      end
    end
    if (c) begin m_err = 0; m_word = 0; end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_locked, m_ep, m_pe, m_err[CNT_W-1:0], m_word[CNT_W-1:0]};
  endfunction

  task automatic step(input logic [7:0] d, input logic v, input logic c);
    data_in = d; data_valid = v; clr_cnt = c;
    @(posedge clk); #1;
    model_step(d, v, c);
    data_valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic send_tx(input int n);
    for (int i = 0; i < n; i++) begin
      step(mk_word(tx), 1'b1, 1'b0);
      tx = nxt7(tx);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; data_in = 8'h00; data_valid = 1'b0; clr_cnt = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    n_checks++; if ({locked, err_pulse, parity_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {locked, err_pulse, parity_err}); end
    n_checks++; if (err_count !== '0 || word_count !== '0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", err_count, word_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(8'h01, 1'b0, 1'b0);
    step(8'h55, 1'b0, 1'b0);
    n_checks++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    tx = 1;
    for (int i = 0; i < 4; i++) begin
      send_tx(1);
      n_checks++; if (locked !== (i == 3)) begin n_fail++; $display("FAIL clean_lock_word%0d locked got=%b exp=%b", i, locked, (i == 3)); end
    end
    send_tx(4);
    n_checks++; if (err_count !== 0 || word_count !== 4) begin n_fail++; $display("FAIL clean_lock_counts got=%0d/%0d exp=0/4", err_count, word_count); end
    n_checks++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL clean_lock_model got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_parity_err();
    do_reset();
    tx = 1;
    send_tx(4);
    step(8'h90, 1'b1, 1'b0);
    tx = nxt7(tx);
    n_checks++; if ({parity_err, err_pulse, locked} !== 3'b111) begin n_fail++; $display("FAIL parity_flags got=%b exp=111", {parity_err, err_pulse, locked}); end
    n_checks++; if (err_count !== 1) begin n_fail++; $display("FAIL parity_errcnt got=%0d exp=1", err_count); end
    send_tx(1);
    n_checks++; if ({parity_err, err_pulse, locked} !== 3'b001 || err_count !== 1 || word_count !== 2) begin n_fail++; $display("FAIL parity_flywheel got=%b/%0d/%0d exp=001/1/2", {parity_err, err_pulse, locked}, err_count, word_count); end
    n_checks++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL parity_model got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_loss_of_lock();
    step(8'h00, 1'b0, 1'b1);
    n_checks++; if (err_count !== 0 || word_count !== 0 || locked !== 1'b1) begin n_fail++; $display("FAIL loss_clr got=%0d/%0d/%b exp=0/0/1", err_count, word_count, locked); end
    for (int i = 0; i < 3; i++) begin
      step(8'h55, 1'b1, 1'b0);
      n_checks++; if (locked !== (i < 2) || err_pulse !== 1'b1) begin n_fail++; $display("FAIL loss_bad%0d got=%b%b exp=%b1", i, locked, err_pulse, (i < 2)); end
    end
    n_checks++; if (err_count !== 3 || word_count !== 3) begin n_fail++; $display("FAIL loss_counts got=%0d/%0d exp=3/3", err_count, word_count); end
  endtask

  task automatic test_resync();
    tx = 7'h41;
    for (int i = 0; i < 4; i++) begin
      send_tx(1);
      n_checks++; if (locked !== (i == 3)) begin n_fail++; $display("FAIL resync_word%0d locked got=%b exp=%b", i, locked, (i == 3)); end
    end
    n_checks++; if (err_count !== 3 || word_count !== 3) begin n_fail++; $display("FAIL resync_counts got=%0d/%0d exp=3/3", err_count, word_count); end
    n_checks++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL resync_model got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_seed_reject();
    logic [7:0] seeds [3];
    logic       pe_exp [3];
    seeds = '{8'h00, 8'h80, 8'h81};
    pe_exp = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(seeds[i], 1'b1, 1'b0);
      n_checks++; if ({parity_err, err_pulse, locked} !== {pe_exp[i], 2'b00}) begin n_fail++; $display("FAIL seed_%h got=%b exp=%b00", seeds[i], {parity_err, err_pulse, locked}, pe_exp[i]); end
    end
    // A rejected lockup word mid-run must restart the count from the next seed.
    tx = 1;
    send_tx(3);
    step(8'h80, 1'b1, 1'b0);
    send_tx(3);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL seed_restart_early got=%b exp=0", locked); end
    send_tx(1);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL seed_restart_lock got=%b exp=1", locked); end
  endtask

  task automatic test_gaps();
    do_reset();
    tx = 1;
    for (int i = 0; i < 12; i++) begin
      send_tx(1);
      if ($urandom_range(0, 1) == 1) begin
        step(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        n_checks++; if (dut_vec !== exp_vec() || err_pulse !== 1'b0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL gap%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
    end
    n_checks++; if (locked !== 1'b1 || err_count !== 0 || word_count !== 8) begin n_fail++; $display("FAIL gaps_end got=%b/%0d/%0d exp=1/0/8", locked, err_count, word_count); end
  endtask

  task automatic test_clr_cnt();
    step(mk_word(tx) ^ 8'h01, 1'b1, 1'b1);
    tx = nxt7(tx);
    n_checks++; if (err_pulse !== 1'b1 || err_count !== 0 || word_count !== 0 || locked !== 1'b1) begin n_fail++; $display("FAIL clr_vs_err got=%b/%0d/%0d/%b exp=1/0/0/1", err_pulse, err_count, word_count, locked); end
    send_tx(1);
    n_checks++; if (err_count !== 0 || word_count !== 1) begin n_fail++; $display("FAIL clr_after got=%0d/%0d exp=0/1", err_count, word_count); end
  endtask

  task automatic test_saturation();
    send_tx(70);
    n_checks++; if (word_count !== CNT_MAX) begin n_fail++; $display("FAIL sat_word got=%0d exp=%0d", word_count, CNT_MAX); end
    for (int i = 0; i < 70; i++) begin
      step(mk_word(tx) ^ 8'h80, 1'b1, 1'b0);
      tx = nxt7(tx);
      send_tx(1);
    end
    n_checks++; if (err_count !== CNT_MAX || locked !== 1'b1) begin n_fail++; $display("FAIL sat_err got=%0d/%b exp=%0d/1", err_count, locked, CNT_MAX); end
    n_checks++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL sat_model got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (locked !== 1'b0 || err_count !== 0 || word_count !== 0) begin n_fail++; $display("FAIL async_rst got=%b/%0d/%0d exp=0/0/0", locked, err_count, word_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_tx(1);
      n_checks++; if (locked !== (i == 3)) begin n_fail++; $display("FAIL async_relock%0d got=%b exp=%b", i, locked, (i == 3)); end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] w;
    do_reset();
    tx = $urandom_range(1, 127);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) tx = nxt7(tx);
      w = mk_word(tx);
      if (r >= 10 && r < 25) w = w ^ 8'($urandom_range(1, 255));
      step(w, (r >= 10) ? 1'b1 : 1'b0, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      if (r >= 10) tx = nxt7(tx);
      n_checks++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_parity_err();
    test_loss_of_lock();
    test_resync();
    test_seed_reject();
    test_gaps();
    test_clr_cnt();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_parity_checker.md
Name: lfsr_parity_checker

Overview:
- Receive-side checker for the 8-bit PRBS-7 word stream from the team's LFSR parity generator.
- The generator's polynomial is x^7+x^6+1, advancing as next(s) = {s[5:0], s[6]^s[5]}. Each word is {p, s[6:0]} with p = ~^s.
- The checker self-synchronises to the stream, verifies each word's parity and sequence continuity, and keeps error and word statistics.
- It sits at the sink end of a loopback or link test path for BIST.

Parameters:
- SYNC_LEN, 4: consecutive good, sequence-consistent words required to declare lock (range 1..15).
- LOSS_LEN, 3: consecutive bad words while locked that force loss of lock (range 1..15).
- CNT_W, 16: width of the error and word counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  received word; bit 7 is parity, bits 6:0 are LFSR state.
- data_valid  input  1  data_in is sampled on this cycle.
- clr_cnt  input  1  synchronous clear of err_count and word_count.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle flag: the sampled word was bad while locked.
- parity_err  output  1  one-cycle flag: the sampled word had a parity violation (any state).
- err_count  output  CNT_W  saturating count of bad words seen while locked.
- word_count  output  CNT_W  saturating count of valid words seen while locked.

Behaviour:
- Reset (rst_n low, async): state=SEARCH, expected=0, run counter=0. locked, err_pulse and parity_err are 0; err_count and word_count are 0.
- Words are only evaluated on a cycle with data_valid=1. On a cycle with data_valid=0 nothing changes, and both pulses are 0.
- good_par is true when data_in[7] == ~^data_in[6:0].
- match is true when data_in[6:0] == expected.
- A word is good when good_par is true and match is true.
- Parity-only errors still count as bad.
- All outputs are registered and reflect the sampled word one cycle after the valid cycle.
- SEARCH state:
  - If good_par and data_in[6:0] != 0, then: set expected = next(data_in[6:0]).
  - Run counter: if the word also matched the previous expected, run += 1; otherwise run = 1 (re-seed).
  - When run reaches SYNC_LEN, go to LOCKED and set run = 0.
  - A word with bad parity, or with data_in[6:0] == 0 (lockup state), sets run = 0 and does not re-seed expected.
  - err_pulse stays 0 in SEARCH; err_count and word_count do not change.
  - With SYNC_LEN=1, the first acceptable seed locks immediately.
- LOCKED state:
  - On every valid cycle: expected = next(expected), flywheel style. Received data never re-seeds expected while locked.
  - word_count += 1, saturating at all-ones.
  - For a bad word: err_pulse=1, err_count += 1 (saturating), bad_run += 1.
  - For a good word: bad_run = 0.
  - When bad_run reaches LOSS_LEN, go to SEARCH, set run = 0 and bad_run = 0, and drop locked on the next cycle. The error that caused the loss is still counted.
- parity_err is pulsed for any valid word with bad parity, in either state.
- clr_cnt:
  - Zeroes both counters on the next edge and takes priority over increments in the same cycle.
  - Does not affect the state, expected, or the run counters.
- Counters saturate: they hold at 2^CNT_W-1 and never wrap.
- Asserting rst_n low mid-stream returns everything to the reset values immediately. After release, a new SYNC_LEN good words are required to lock.

Test Plan:
- Clean lock: after reset, stream 01,02,04,08 with valid every cycle and defaults → locked=1 one cycle after 0x08 is sampled. Continue C1? No: continue 10,20,C1,83 → err_count stays 0 and word_count=4.
- Parity error: while locked, send 0x90 instead of 0x10 → parity_err=1 and err_pulse=1 for one cycle, err_count=1, locked stays 1. The following 0x20 is good, because expected flywheels.
- Loss of lock: while locked, inject 3 consecutive corrupted words (0x55) → err_count=3, and locked falls to 0 the cycle after the third.
- Re-sync: after loss of lock, resume the sequence at 0x41? No: resume at 0xC1,0x83,... → re-lock after 4 good words; err_count is unchanged.
- Seed rejection: in SEARCH, send 0x00 then 0x80, then a bad-parity 0x81 → locked stays 0, parity_err pulses on 0x00 (parity bit wrong) and on 0x81; 0x80 is rejected as the lockup state without a pulse.
- Gaps and control: insert data_valid=0 bubbles mid-stream (no state advance, no error). Assert clr_cnt coincident with an error → counters read 0. Pulse rst_n low while locked → locked=0 and counters=0 immediately.
